// File: rtl/vm_pkg.sv
// Shared types and coin helpers for the vending controller.
// Coin codes, denomination values and the greedy change selector.
package vm_pkg;

  localparam int AMT_W = 16;

  localparam logic [2:0] COIN_5   = 3'd0;
  localparam logic [2:0] COIN_10  = 3'd1;
  localparam logic [2:0] COIN_25  = 3'd2;
  localparam logic [2:0] COIN_50  = 3'd3;
  localparam logic [2:0] COIN_100 = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_VEND    = 3'd2,
    ST_CHANGE  = 3'd3,
    ST_DONE    = 3'd4
  } vm_state_e;

  function automatic logic coin_is_valid(input logic [2:0] code);
    return code <= COIN_100;
  endfunction

  function automatic logic [7:0] coin_value(input logic [2:0] code);
    case (code)
      COIN_5:   return 8'd5;
      COIN_10:  return 8'd10;
      COIN_25:  return 8'd25;
      COIN_50:  return 8'd50;
      COIN_100: return 8'd100;
      default:  return 8'd0;
    endcase
  endfunction

  function automatic logic [2:0] max_denom(input logic [AMT_W-1:0] amt);
    if (amt >= AMT_W'(100)) return COIN_100;
    if (amt >= AMT_W'(50))  return COIN_50;
    if (amt >= AMT_W'(25))  return COIN_25;
    if (amt >= AMT_W'(10))  return COIN_10;
    return COIN_5;
  endfunction

endpackage

// File: rtl/vm_change_dispenser.sv
// Greedy change dispenser: loads an amount, emits one coin per
// ready/valid handshake, pulses done on the final coin.
module vm_change_dispenser
  import vm_pkg::*;
#(
  parameter int CREDIT_W = 12
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [CREDIT_W-1:0] i_amount,
  input  logic                i_rdy,
  output logic                o_vld,
  output logic [2:0]          o_code,
  output logic [CREDIT_W-1:0] o_remain,
  output logic                o_done
);

  logic [CREDIT_W-1:0] rem_q, rem_d;
  logic [CREDIT_W-1:0] coin;

  // Coin is derived from the registered remainder only, so it holds
  // steady while the mechanism applies backpressure.
  always_comb begin
    o_code = max_denom(AMT_W'(rem_q));
    coin   = CREDIT_W'(coin_value(o_code));
    o_vld  = rem_q != '0;
    o_done = o_vld && i_rdy && (rem_q == coin);
    rem_d  = rem_q;
    if (i_start)
      rem_d = i_amount;
    else if (o_vld && i_rdy)
      rem_d = rem_q - coin;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) rem_q <= '0;
    else          rem_q <= rem_d;
  end

  assign o_remain = rem_q;

endmodule

// File: rtl/vending_ctrl_gen2.sv
// Second-generation vending controller: select, collect, vend,
// greedy change and idle timeout.
module vending_ctrl_gen2
  import vm_pkg::*;
#(
  parameter int NUM_ITEMS = 8,
  parameter int PRICE_W   = 10,
  parameter logic [NUM_ITEMS*PRICE_W-1:0] PRICE_TABLE = {
    10'd300, 10'd25, 10'd200, 10'd150,
    10'd120, 10'd100, 10'd80, 10'd50},
  parameter int MAX_QTY     = 3,
  parameter int CREDIT_W    = 12,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_sel_vld,
  input  logic [$clog2(NUM_ITEMS)-1:0] i_sel_item,
  input  logic                         i_qty_vld,
  input  logic [2:0]                   i_qty,
  input  logic                         i_coin_vld,
  input  logic [2:0]                   i_coin_code,
  input  logic                         i_cancel,
  input  logic                         i_continue,
  output logic                         o_coin_rej,
  output logic [CREDIT_W-1:0]          o_credit,
  output logic [$clog2(NUM_ITEMS)-1:0] o_item,
  output logic [2:0]                   o_qty,
  output logic                         o_vend_vld,
  output logic [$clog2(NUM_ITEMS)-1:0] o_vend_item,
  output logic [2:0]                   o_vend_qty,
  input  logic                         i_vend_rdy,
  output logic                         o_chg_vld,
  output logic [2:0]                   o_chg_code,
  input  logic                         i_chg_rdy,
  output logic [CREDIT_W-1:0]          o_chg_remain,
  output logic                         o_done,
  output logic [2:0]                   o_state
);

  localparam int IW = $clog2(NUM_ITEMS);
  localparam int CW = PRICE_W + 3;
  localparam int MW = (CREDIT_W > CW) ? CREDIT_W : CW;
  localparam int TW = $clog2(TIMEOUT_CYC) + 1;

  vm_state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [IW-1:0] item_q, item_d;
  logic [2:0] qty_q, qty_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic rej_q, rej_d;

  logic [PRICE_W-1:0] price;
  logic [CW-1:0] cost;
  logic [CREDIT_W:0] coin_sum;
  logic [CREDIT_W-1:0] chg_amt;
  logic in_collect, paid, sel_ok, qty_ok;
  logic cfg_ok, coin_ok, evt, tmo_hit;
  logic chg_start, chg_done;

  assign price      = PRICE_TABLE[int'(item_q)*PRICE_W +: PRICE_W];
  assign cost       = CW'(price) * CW'(qty_q);
  assign paid       = MW'(credit_q) >= MW'(cost);
  assign in_collect = state_q == ST_COLLECT;
  assign sel_ok     = i_sel_vld && (32'(i_sel_item) < NUM_ITEMS);
  assign qty_ok     = i_qty_vld && (i_qty != 3'd0)
                      && (32'(i_qty) <= MAX_QTY);
  assign coin_sum   = {1'b0, credit_q}
                      + (CREDIT_W+1)'(coin_value(i_coin_code));
  // Selection is frozen once paid so the cost cannot move under VEND.
  assign cfg_ok     = in_collect && !i_cancel && !paid;
  assign coin_ok    = in_collect && !i_cancel && i_coin_vld
                      && coin_is_valid(i_coin_code)
                      && !coin_sum[CREDIT_W];
  assign evt        = coin_ok || (cfg_ok && (sel_ok || qty_ok));
  assign tmo_hit    = (tmo_q == TW'(TIMEOUT_CYC-1)) && !evt;
  assign chg_start  = (state_d == ST_CHANGE) && (state_q != ST_CHANGE);
  assign chg_amt    = (state_q == ST_VEND)
                      ? credit_q - CREDIT_W'(cost) : credit_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (sel_ok) state_d = ST_COLLECT;
      ST_COLLECT:
        if (i_cancel || (!paid && tmo_hit))
          state_d = (credit_q != '0) ? ST_CHANGE : ST_DONE;
        else if (paid)
          state_d = ST_VEND;
      ST_VEND:
        if (i_vend_rdy)
          state_d = (credit_q != CREDIT_W'(cost)) ? ST_CHANGE : ST_DONE;
      ST_CHANGE:
        if (chg_done) state_d = ST_DONE;
      ST_DONE:
        if (i_continue || tmo_hit) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    item_d   = item_q;
    qty_d    = qty_q;
    rej_d    = i_coin_vld && !coin_ok;
    tmo_d    = (in_collect || state_q == ST_DONE) ? tmo_q + 1'b1 : '0;
    if (evt || state_d != state_q) tmo_d = '0;
    unique case (state_q)
      ST_IDLE:
        if (sel_ok) begin
          item_d = i_sel_item;
          qty_d  = 3'd1;
        end
      ST_COLLECT: begin
        if (coin_ok) credit_d = coin_sum[CREDIT_W-1:0];
        if (cfg_ok && sel_ok) item_d = i_sel_item;
        if (cfg_ok && qty_ok) qty_d = i_qty;
        if (state_d == ST_CHANGE || state_d == ST_DONE) credit_d = '0;
      end
      ST_VEND:
        if (i_vend_rdy) credit_d = '0;
      ST_DONE:
        if (state_d == ST_IDLE) begin
          item_d   = '0;
          qty_d    = 3'd1;
          credit_d = '0;
        end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      credit_q <= '0;
      item_q   <= '0;
      qty_q    <= 3'd1;
      tmo_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      item_q   <= item_d;
      qty_q    <= qty_d;
      tmo_q    <= tmo_d;
      rej_q    <= rej_d;
    end
  end

  vm_change_dispenser #(.CREDIT_W(CREDIT_W)) u_chg (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_start  (chg_start),
    .i_amount (chg_amt),
    .i_rdy    (i_chg_rdy),
    .o_vld    (o_chg_vld),
    .o_code   (o_chg_code),
    .o_remain (o_chg_remain),
    .o_done   (chg_done)
  );

  always_comb begin
    o_state     = state_q;
    o_vend_vld  = state_q == ST_VEND;
    o_done      = state_q == ST_DONE;
    o_vend_item = item_q;
    o_vend_qty  = qty_q;
    o_item      = item_q;
    o_qty       = qty_q;
    o_credit    = credit_q;
    o_coin_rej  = rej_q;
  end

endmodule

// File: tb/tb_vending_ctrl_gen2.sv
// Directed scoreboard bench for vending_ctrl_gen2 with a narrow
// credit width and short timeout.
module tb_vending_ctrl_gen2;

  localparam int CW = 8;
  localparam int TMO = 16;
  localparam int S_IDLE = 0, S_COL = 1, S_VEND = 2;
  localparam int S_CHG = 3, S_DONE = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic sel_vld, qty_vld, coin_vld, cancel, cont;
  logic [2:0] sel_item, qty, coin_code;
  logic vend_rdy, chg_rdy;
  logic coin_rej, vend_vld, chg_vld, done;
  logic [CW-1:0] credit, chg_remain;
  logic [2:0] item, oqty, vend_item, vend_qty, chg_code, state;

  int n_cmp = 0;
  int n_err = 0;
  int vend_cnt = 0;
  int exp_vend[$];
  int exp_chg[$];

  always #5 clk = ~clk;

  vending_ctrl_gen2 #(.CREDIT_W(CW), .TIMEOUT_CYC(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_sel_vld(sel_vld), .i_sel_item(sel_item),
    .i_qty_vld(qty_vld), .i_qty(qty),
    .i_coin_vld(coin_vld), .i_coin_code(coin_code),
    .i_cancel(cancel), .i_continue(cont),
    .o_coin_rej(coin_rej), .o_credit(credit),
    .o_item(item), .o_qty(oqty),
    .o_vend_vld(vend_vld), .o_vend_item(vend_item),
    .o_vend_qty(vend_qty), .i_vend_rdy(vend_rdy),
    .o_chg_vld(chg_vld), .o_chg_code(chg_code),
    .i_chg_rdy(chg_rdy), .o_chg_remain(chg_remain),
    .o_done(done), .o_state(state)
  );

  always @(posedge clk)
    if (rst_n && vend_vld && vend_rdy) vend_cnt <= vend_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_sel(input int it);
    sel_vld = 1'b1; sel_item = 3'(it);
    tick();
    sel_vld = 1'b0;
  endtask

  task automatic do_qty(input int q);
    qty_vld = 1'b1; qty = 3'(q);
    tick();
    qty_vld = 1'b0;
  endtask

  task automatic do_coin(input int code);
    coin_vld = 1'b1; coin_code = 3'(code);
    tick();
    coin_vld = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
  endtask

  task automatic do_continue();
    cont = 1'b1;
    tick();
    cont = 1'b0;
  endtask

  function automatic void push_change(input int amt);
    int a = amt;
    while (a > 0) begin
      if (a >= 100)     begin exp_chg.push_back(4); a -= 100; end
      else if (a >= 50) begin exp_chg.push_back(3); a -= 50; end
      else if (a >= 25) begin exp_chg.push_back(2); a -= 25; end
      else if (a >= 10) begin exp_chg.push_back(1); a -= 10; end
      else              begin exp_chg.push_back(0); a -= 5; end
    end
  endfunction

  task automatic wait_state(input string tag, input int st,
                            input int budget, output int n);
    n = 0;
    while (int'(state) != st && n < budget) begin
      tick();
      n++;
    end
    check(tag, int'(state), st);
  endtask

  task automatic run_vend(input string tag);
    int n;
    int e;
    wait_state({tag, "_vend_state"}, S_VEND, 8, n);
    check({tag, "_vend_vld"}, int'(vend_vld), 1);
    e = (exp_vend.size() > 0) ? exp_vend.pop_front() : -1;
    check({tag, "_vend_payload"}, int'(vend_item) * 8 + int'(vend_qty), e);
    vend_rdy = 1'b1;
    tick();
    vend_rdy = 1'b0;
  endtask

  task automatic drain_change(input string tag);
    int n = 0;
    chg_rdy = 1'b1;
    while (int'(state) == S_CHG && n < 40) begin
      if (chg_vld) begin
        if (exp_chg.size() > 0)
          check({tag, "_chg_code"}, int'(chg_code), exp_chg.pop_front());
        else
          check({tag, "_chg_extra"}, exp_chg.size(), 1);
      end
      tick();
      n++;
    end
    chg_rdy = 1'b0;
    check({tag, "_chg_left"}, exp_chg.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0;
    sel_vld = 0; qty_vld = 0; coin_vld = 0; cancel = 0; cont = 0;
    sel_item = 0; qty = 0; coin_code = 0;
    vend_rdy = 0; chg_rdy = 0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    check("rst_state", int'(state), S_IDLE);
    check("rst_qty", int'(oqty), 1);
    check("rst_credit", int'(credit), 0);
    check("rst_outs", {vend_vld, chg_vld, done, coin_rej}, 0);

    // item 1 (80), 50+50, change 20
    do_sel(1);
    check("t1_state", int'(state), S_COL);
    check("t1_item", int'(item), 1);
    do_coin(3);
    do_coin(3);
    check("t1_credit", int'(credit), 100);
    exp_vend.push_back(1 * 8 + 1);
    push_change(20);
    run_vend("t1");
    check("t1_remain", int'(chg_remain), 20);
    drain_change("t1");
    check("t1_done", int'(done), 1);
    do_continue();
    check("t1_idle", int'(state), S_IDLE);
    check("t1_item_clr", int'(item), 0);

    // item 0 qty 3, exact payment
    do_sel(0);
    do_qty(3);
    check("t2_qty", int'(oqty), 3);
    do_coin(4);
    do_coin(3);
    check("t2_credit", int'(credit), 150);
    exp_vend.push_back(0 * 8 + 3);
    run_vend("t2");
    check("t2_direct_done", int'(state), S_DONE);
    check("t2_credit_clr", int'(credit), 0);
    do_continue();

    // item 4 (150), 125 then cancel with a coin in the same cycle
    do_sel(4);
    do_coin(4);
    do_coin(2);
    check("t3_credit", int'(credit), 125);
    cancel = 1'b1; coin_vld = 1'b1; coin_code = 3'd3;
    tick();
    cancel = 1'b0; coin_vld = 1'b0;
    check("t3_state", int'(state), S_CHG);
    check("t3_rej", int'(coin_rej), 1);
    check("t3_remain", int'(chg_remain), 125);
    push_change(125);
    drain_change("t3");
    check("t3_vends", vend_cnt, 2);
    do_continue();

    // inactivity timeout in COLLECT and in DONE
    do_sel(2);
    do_coin(0);
    check("t4_credit", int'(credit), 5);
    wait_state("t4_to_change", S_CHG, 40, n);
    check("t4_cycles", n, TMO);
    push_change(5);
    drain_change("t4");
    check("t4_done", int'(state), S_DONE);
    wait_state("t4_to_idle", S_IDLE, 40, n);
    check("t4_item_clr", int'(item), 0);

    // change 35 with backpressure
    do_sel(4);
    do_coin(2);
    do_coin(1);
    do_cancel();
    push_change(35);
    for (int i = 0; i < 5; i++) begin
      check("t5_stall_vld", int'(chg_vld), 1);
      check("t5_stall_code", int'(chg_code), exp_chg[0]);
      check("t5_stall_remain", int'(chg_remain), 35);
      tick();
    end
    chg_rdy = 1'b1;
    tick();
    void'(exp_chg.pop_front());
    check("t5_remain_10", int'(chg_remain), 10);
    check("t5_code_2nd", int'(chg_code), exp_chg[0]);
    tick();
    void'(exp_chg.pop_front());
    chg_rdy = 1'b0;
    check("t5_remain_0", int'(chg_remain), 0);
    check("t5_done", int'(state), S_DONE);
    do_continue();

    // rejections: IDLE coin, invalid code, overflow
    do_coin(4);
    check("t6_idle_rej", int'(coin_rej), 1);
    check("t6_idle_credit", int'(credit), 0);
    tick();
    check("t6_rej_pulse", int'(coin_rej), 0);
    do_sel(7);
    do_coin(6);
    check("t6_bad_rej", int'(coin_rej), 1);
    check("t6_bad_credit", int'(credit), 0);
    do_coin(4);
    do_coin(4);
    do_coin(3);
    check("t6_credit_250", int'(credit), 250);
    do_coin(1);
    check("t6_ovf_rej", int'(coin_rej), 1);
    check("t6_ovf_credit", int'(credit), 250);
    do_coin(0);
    check("t6_fill_rej", int'(coin_rej), 0);
    check("t6_credit_255", int'(credit), 255);
    do_cancel();
    push_change(255);
    drain_change("t6");
    do_continue();

    // reset in the middle of CHANGE
    do_sel(4);
    do_coin(4);
    do_cancel();
    check("t7_in_change", int'(chg_vld), 1);
    chg_rdy = 1'b1;
    rst_n = 1'b0;
    tick();
    chg_rdy = 1'b0;
    check("t7_state", int'(state), S_IDLE);
    check("t7_remain", int'(chg_remain), 0);
    check("t7_credit", int'(credit), 0);
    check("t7_qty", int'(oqty), 1);
    check("t7_item", int'(item), 0);
    check("t7_outs", {vend_vld, chg_vld, done, coin_rej}, 0);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vending_ctrl_gen2.md
Name: vending_ctrl_gen2

Overview:
Parametrised second-generation vending-machine controller. Supports NUM_ITEMS products with a per-item price table, a programmable maximum quantity and coded coin input. Adds features the first generation lacks: credit saturation, an inactivity timeout, ready/valid vend and change-dispense handshakes, and greedy coin-by-coin change output. Sits between the keypad/coin front end and the display/dispense mechanics.

Parameters:
NUM_ITEMS, 8, number of selectable products (2..16)
PRICE_W, 10, width of one price entry
PRICE_TABLE, {300,25,200,150,120,100,80,50}, NUM_ITEMS*PRICE_W packed prices; item 0 in LSBs; every price a multiple of 5 and nonzero
MAX_QTY, 3, largest quantity per purchase (1..7)
CREDIT_W, 12, credit accumulator width
TIMEOUT_CYC, 1000, idle cycles in COLLECT/DONE before auto-cancel/auto-return

Ports:
i_clk  in  1  clock
i_rst_n  in  1  synchronous active-low reset
i_sel_vld  in  1  item-select pulse
i_sel_item  in  $clog2(NUM_ITEMS)  item index
i_qty_vld  in  1  quantity-select pulse
i_qty  in  3  requested quantity
i_coin_vld  in  1  coin-inserted pulse
i_coin_code  in  3  0=5, 1=10, 2=25, 3=50, 4=100; 5..7 invalid
i_cancel  in  1  cancel request, active-high level
i_continue  in  1  continue pulse
o_coin_rej  out  1  one-cycle pulse: coin not credited
o_credit  out  CREDIT_W  current credit
o_item  out  $clog2(NUM_ITEMS)  selected item
o_qty  out  3  selected quantity
o_vend_vld  out  1  vend request
o_vend_item/o_vend_qty  out  as o_item/o_qty  vend payload
i_vend_rdy  in  1  mechanism accepted vend
o_chg_vld  out  1  change coin valid
o_chg_code  out  3  denomination code (coin encoding)
i_chg_rdy  in  1  coin ejected
o_chg_remain  out  CREDIT_W  change still owed
o_done  out  1  high in DONE
o_state  out  3  state encoding, debug

Behaviour:
- Reset (i_rst_n=0 at posedge): state IDLE. All outputs 0 except o_qty=1. Credit, change and timeout counter cleared. Applies from any state, mid-handshake included. Handshakes are dropped with no completion.
- IDLE: credit 0. Any coin → o_coin_rej. i_sel_vld with index < NUM_ITEMS → latch item, qty=1, go to COLLECT. Out-of-range index is ignored.
- COLLECT: coin with a valid code adds its value to credit on the next edge (1-cycle latency). Invalid code → reject. A coin that would exceed 2^CREDIT_W-1 → reject, credit unchanged.
- COLLECT: i_qty_vld with 1 ≤ i_qty ≤ MAX_QTY latches qty; other values are ignored. i_sel_vld re-selects the item.
- COLLECT: cost = price[item]*qty, width PRICE_W+3. When the registered credit ≥ cost → VEND at the next edge.
- COLLECT exit on cancel or timeout: i_cancel, or timeout counter = TIMEOUT_CYC-1, → CHANGE with change = credit (DONE if credit = 0). Priority: cancel > coin; a coin arriving in the cancel cycle is rejected.
- Timeout counter clears on any accepted sel/qty/coin event and on state entry.
- VEND: o_vend_vld=1 with stable item/qty until i_vend_rdy. Cancel and coins are rejected or ignored here (committed). On handshake: change = credit − cost, credit cleared. Go to CHANGE if change > 0, else DONE.
- CHANGE: o_chg_code = largest denomination ≤ o_chg_remain, with o_chg_vld=1. On i_chg_rdy, subtract that value next cycle. The coin is recomputed each cycle from the registered remainder, so code and vld stay stable under backpressure. Remainder 0 → DONE. Cancel is ignored.
- DONE: o_done=1. i_continue or timeout → IDLE; o_item, o_qty and credit reset.
- Coin in VEND/CHANGE/DONE → o_coin_rej.
- Prices are multiples of 5 and coins are multiples of 5, so greedy change always terminates exactly.

Decomposition:
- Shared package vm_pkg: coin-code constants, denomination value function (code → value), state encoding, and the max-denomination-≤-amount function.
- One sub-module, vm_change_dispenser: load/remainder register plus greedy selector and ready/valid output. It takes a start pulse and an amount and returns a done pulse.

Test Plan:
- Select item 1 (80), insert 50, 50 → credit 100; o_vend_vld item 1 qty 1; after rdy, change coins 10, 10; o_done; continue → IDLE.
- Select item 0, qty 3 (cost 150), insert 100, 50 → VEND qty 3; no CHANGE state; DONE directly.
- Select item 4 (150), insert 100, 25, assert i_cancel → change 125 emitted as codes 4, 2; no vend.
- TIMEOUT_CYC=16: select item, insert 5, idle 16 cycles → change code 0; DONE; another 16 idle cycles → IDLE.
- Backpressure: i_chg_rdy low 5 cycles during change 35 → code 2 stable with vld, then 10 appears; o_chg_remain steps 35 → 10 → 0.
- Coin code 6 in COLLECT, any coin in IDLE, and CREDIT_W=8 overflow coin → o_coin_rej pulse, credit unchanged. Reset asserted mid-CHANGE → all outputs at reset values next cycle.
